// File: rtl/hp_responder_ram.sv
// AXI3 responder backed by a word-addressed RAM, one transaction at a time.
// Optional macro HP_RESPONDER_WLAST_CHECK_EN turns a wlast mismatch into SLVERR.
module hp_responder_ram #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clock_i,
   input  logic        reset_i,
   // write address
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [5:0]  awid_i,
   input  logic [31:0] awaddr_i,
   input  logic [3:0]  awlen_i,
   input  logic [1:0]  awburst_i,
   // write data
   input  logic        wvalid_i,
   output logic        wready_o,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wlast_i,
   // write response
   output logic        bvalid_o,
   input  logic        bready_i,
   output logic [5:0]  bid_o,
   output logic [1:0]  bresp_o,
   // read address
   input  logic        arvalid_i,
   output logic        arready_o,
   input  logic [5:0]  arid_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arlen_i,
   input  logic [1:0]  arburst_i,
   // read data
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic [5:0]  rid_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rlast_o
);

   localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [32:0] ADDR_LO     = 33'(BASE_ADDR);
   localparam logic [32:0] ADDR_HI     = 33'(BASE_ADDR) + (33'(DEPTH) << 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_WRESP,
      ST_RFETCH,
      ST_RDATA
   } state_e;

   state_e      state_q;
   logic        idle_rdy_q;
   logic        wready_q;
   logic        bvalid_q;
   logic        rvalid_q;
   logic        rlast_q;
   logic [31:0] rdata_q;
   logic [5:0]  id_q;
   logic [29:0] start_q;
   logic [3:0]  len_q;
   logic [3:0]  beat_q;
   logic [1:0]  err_q;
   logic [31:0] mem_q [DEPTH];

   logic        aw_hs_c;
   logic        ar_hs_c;
   logic        w_hs_c;
   logic [29:0] acc_start_c;
   logic [3:0]  acc_len_c;
   logic [1:0]  acc_burst_c;
   logic [32:0] acc_first_c;
   logic [32:0] acc_last_c;
   logic [1:0]  acc_err_c;
   logic [32:0] beat_addr_c;
   logic        beat_in_range_c;
   logic [AW-1:0] word_idx_c;
   logic        wlast_bad_c;
   logic [1:0]  w_err_c;
   logic        mem_we_c;
   logic        unused_c;

   // A write wins the IDLE arbitration, so arready masks itself with awvalid.
   assign awready_o = idle_rdy_q;
   assign arready_o = idle_rdy_q & ~awvalid_i;
   assign aw_hs_c   = idle_rdy_q & awvalid_i;
   assign ar_hs_c   = arready_o & arvalid_i;
   assign w_hs_c    = (state_q == ST_WDATA) & wvalid_i;

   assign wready_o  = wready_q;
   assign bvalid_o  = bvalid_q;
   assign bid_o     = id_q;
   assign bresp_o   = err_q;
   assign rvalid_o  = rvalid_q;
   assign rid_o     = id_q;
   assign rdata_o   = rdata_q;
   assign rresp_o   = err_q;
   assign rlast_o   = rlast_q;

   // Whole-burst range check at address accept; contiguous beats need only the ends.
   assign acc_start_c = awvalid_i ? awaddr_i[31:2]  : araddr_i[31:2];
   assign acc_len_c   = awvalid_i ? awlen_i         : arlen_i;
   assign acc_burst_c = awvalid_i ? awburst_i       : arburst_i;
   assign acc_first_c = {1'b0, acc_start_c, 2'b00};
   assign acc_last_c  = acc_first_c + (33'(acc_len_c) << 2);
   assign acc_err_c   = (acc_burst_c != BURST_INCR)                          ? RESP_SLVERR :
                        ((acc_first_c < ADDR_LO) || (acc_last_c >= ADDR_HI)) ? RESP_DECERR :
                                                                               RESP_OKAY;

   // Current beat address in 33 bits so a burst near 2^32 cannot wrap into the RAM.
   assign beat_addr_c     = {1'b0, start_q, 2'b00} + (33'(beat_q) << 2);
   assign beat_in_range_c = (beat_addr_c >= ADDR_LO) && (beat_addr_c < ADDR_HI);
   assign word_idx_c      = AW'((beat_addr_c - ADDR_LO) >> 2);

`ifdef HP_RESPONDER_WLAST_CHECK_EN
   assign wlast_bad_c = wlast_i ^ (beat_q == len_q);
   assign unused_c    = ^{awaddr_i[1:0], araddr_i[1:0]};
`else
   assign wlast_bad_c = 1'b0;
   assign unused_c    = ^{awaddr_i[1:0], araddr_i[1:0], wlast_i};
`endif

   assign w_err_c  = wlast_bad_c ? RESP_SLVERR : err_q;
   assign mem_we_c = w_hs_c & (err_q != RESP_SLVERR) & beat_in_range_c & ~reset_i;

   // Transaction FSM with registered handshake outputs.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         idle_rdy_q <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rdata_q    <= '0;
         id_q       <= '0;
         start_q    <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         err_q      <= RESP_OKAY;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (aw_hs_c || ar_hs_c) begin
                  id_q       <= awvalid_i ? awid_i : arid_i;
                  start_q    <= acc_start_c;
                  len_q      <= acc_len_c;
                  err_q      <= acc_err_c;
                  beat_q     <= '0;
                  idle_rdy_q <= 1'b0;
                  if (aw_hs_c) begin
                     wready_q <= 1'b1;
                     state_q  <= ST_WDATA;
                  end else begin
                     state_q  <= ST_RFETCH;
                  end
               end else begin
                  idle_rdy_q <= 1'b1;
               end
            end
            ST_WDATA: begin
               if (w_hs_c) begin
                  err_q <= w_err_c;
                  if (beat_q == len_q) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     state_q  <= ST_WRESP;
                  end else begin
                     beat_q <= beat_q + 4'd1;
                  end
               end
            end
            ST_WRESP: begin
               if (bready_i) begin
                  bvalid_q   <= 1'b0;
                  idle_rdy_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            ST_RFETCH: begin
               rdata_q  <= ((err_q != RESP_SLVERR) && beat_in_range_c) ? mem_q[word_idx_c] : 32'h0;
               rlast_q  <= (beat_q == len_q);
               rvalid_q <= 1'b1;
               state_q  <= ST_RDATA;
            end
            ST_RDATA: begin
               if (rready_i) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  if (rlast_q) begin
                     idle_rdy_q <= 1'b1;
                     state_q    <= ST_IDLE;
                  end else begin
                     beat_q  <= beat_q + 4'd1;
                     state_q <= ST_RFETCH;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Byte-enabled RAM write port; contents survive reset.
   always_ff @(posedge clock_i) begin
      if (mem_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) begin
               mem_q[word_idx_c][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

endmodule
